// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM read-modify-write front end.
// Byte-enable helpers take a zero-padded vector so one function serves any word width.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    RMW_WR = 2'd2
  } state_e;

  // Widest byte-enable vector the helpers accept (1024-bit words).
  localparam int MAX_BE_WIDTH = 128;

  function automatic logic be_all_ones(input logic [MAX_BE_WIDTH-1:0] ben, input int width);
    logic all;
    all = 1'b1;
    for (int i = 0; i < MAX_BE_WIDTH; i++) begin
      if ((i < width) && !ben[i]) all = 1'b0;
    end
    return all;
  endfunction

  function automatic logic be_none(input logic [MAX_BE_WIDTH-1:0] ben, input int width);
    logic none;
    none = 1'b1;
    for (int i = 0; i < MAX_BE_WIDTH; i++) begin
      if ((i < width) && ben[i]) none = 1'b0;
    end
    return none;
  endfunction

endpackage

// File: rtl/sram_be_merge.sv
// Byte-granular merge of new write data over the old word read back from the macro.
module sram_be_merge #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] ben,
  output logic [DATA_WIDTH-1:0]   merged
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  always_comb begin
    merged = old_data;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (ben[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/sram_rmw_ctrl.sv
// Request front end for a single-port SRAM macro with all-ones write mask: emulates
// byte-enable writes via read-modify-write and zero-sweeps the array after reset or flush.
module sram_rmw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 8,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_SI,
  input  logic                    Flush_SI,
  input  logic                    Req_SI,
  output logic                    Gnt_SO,
  input  logic                    We_SI,
  input  logic [DATA_WIDTH/8-1:0] BEn_SI,
  input  logic [ADDR_WIDTH-1:0]   Addr_DI,
  input  logic [DATA_WIDTH-1:0]   WrData_DI,
  output logic                    RVld_SO,
  output logic [DATA_WIDTH-1:0]   RdData_DO,
  output logic                    InitDone_SO,
  output logic                    SramCSel_SO,
  output logic                    SramWrEn_SO,
  output logic [ADDR_WIDTH-1:0]   SramAddr_DO,
  output logic [DATA_WIDTH-1:0]   SramWrData_DO,
  input  logic [DATA_WIDTH-1:0]   SramRdData_DI
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam state_e RESET_STATE = INIT_ON_RESET ? INIT : IDLE;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    rvld_q, rvld_d;
  logic                    rmw_load;
  logic [ADDR_WIDTH-1:0]   rmw_addr_q;
  logic [DATA_WIDTH-1:0]   rmw_data_q;
  logic [BE_WIDTH-1:0]     rmw_ben_q;
  logic [MAX_BE_WIDTH-1:0] ben_ext;
  logic                    ben_all;
  logic                    ben_none;
  logic [DATA_WIDTH-1:0]   merged_data;

  always_comb begin
    ben_ext = '0;
    ben_ext[BE_WIDTH-1:0] = BEn_SI;
    ben_all  = be_all_ones(ben_ext, BE_WIDTH);
    ben_none = be_none(ben_ext, BE_WIDTH);
  end

  // The macro returns the old word in RMW_WR; overlay the registered enabled bytes on it.
  sram_be_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_merge (
    .old_data(SramRdData_DI),
    .new_data(rmw_data_q),
    .ben     (rmw_ben_q),
    .merged  (merged_data)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    init_done_d   = init_done_q;
    rvld_d        = 1'b0;
    rmw_load      = 1'b0;
    Gnt_SO        = 1'b0;
    SramCSel_SO   = 1'b0;
    SramWrEn_SO   = 1'b0;
    SramAddr_DO   = '0;
    SramWrData_DO = '0;

    case (state_q)
      INIT: begin
        SramCSel_SO = 1'b1;
        SramWrEn_SO = 1'b1;
        SramAddr_DO = cnt_q;
        cnt_d       = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end

      IDLE: begin
        Gnt_SO = !Flush_SI;
        if (Flush_SI) begin
          state_d     = INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else if (Req_SI) begin
          SramAddr_DO = Addr_DI;
          if (!We_SI) begin
            SramCSel_SO = 1'b1;
            rvld_d      = 1'b1;
          end else if (ben_all) begin
            SramCSel_SO   = 1'b1;
            SramWrEn_SO   = 1'b1;
            SramWrData_DO = WrData_DI;
          end else if (!ben_none) begin
            // Partial write: fetch the old word now, write the merge next cycle.
            SramCSel_SO = 1'b1;
            rmw_load    = 1'b1;
            state_d     = RMW_WR;
          end
        end
      end

      RMW_WR: begin
        SramCSel_SO   = 1'b1;
        SramWrEn_SO   = 1'b1;
        SramAddr_DO   = rmw_addr_q;
        SramWrData_DO = merged_data;
        state_d       = IDLE;
      end

      default: state_d = RESET_STATE;
    endcase

    // Reset kills any macro access in flight, including a pending RMW write.
    if (Rst_SI) begin
      Gnt_SO      = 1'b0;
      SramCSel_SO = 1'b0;
      SramWrEn_SO = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      init_done_q <= !INIT_ON_RESET;
      rvld_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rvld_q      <= rvld_d;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (rmw_load) begin
      rmw_addr_q <= Addr_DI;
      rmw_data_q <= WrData_DI;
      rmw_ben_q  <= BEn_SI;
    end
  end

  assign RVld_SO     = rvld_q;
  assign RdData_DO   = SramRdData_DI;
  assign InitDone_SO = init_done_q;

  a_wren_needs_csel: assert property (@(posedge Clk_CI) disable iff (Rst_SI)
    SramWrEn_SO |-> SramCSel_SO);
  a_no_grant_in_rmw: assert property (@(posedge Clk_CI) disable iff (Rst_SI)
    (state_q == RMW_WR) |-> !Gnt_SO);

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Self-checking bench for sram_rmw_ctrl: behavioural macro model, vector table and
// a read-data scoreboard, plus hand sequences for sweep, flush and reset corners.
module tb_sram_rmw_ctrl;

  localparam int DW    = 64;
  localparam int AW    = 8;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam int NVEC  = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          req;
  logic          gnt;
  logic          we_i;
  logic [BW-1:0] ben_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          rvld;
  logic [DW-1:0] rdata;
  logic          init_done;
  logic          sram_csel;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  logic [DW-1:0] sram_mem [DEPTH];

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_q[$];
  logic          rd_issue = 1'b0;
  logic          exp_rvld = 1'b0;

  typedef struct {
    logic          we;
    logic [BW-1:0] ben;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  // Single-port macro: write or read on CSel, read data registered one cycle later.
  always @(posedge clk) begin
    if (sram_csel) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  sram_rmw_ctrl #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .INIT_ON_RESET(1'b1)
  ) dut (
    .Clk_CI       (clk),
    .Rst_SI       (rst),
    .Flush_SI     (flush),
    .Req_SI       (req),
    .Gnt_SO       (gnt),
    .We_SI        (we_i),
    .BEn_SI       (ben_i),
    .Addr_DI      (addr_i),
    .WrData_DI    (wdata_i),
    .RVld_SO      (rvld),
    .RdData_DO    (rdata),
    .InitDone_SO  (init_done),
    .SramCSel_SO  (sram_csel),
    .SramWrEn_SO  (sram_we),
    .SramAddr_DO  (sram_addr),
    .SramWrData_DO(sram_wdata),
    .SramRdData_DI(sram_rdata)
  );

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Read valid is expected exactly one cycle after each issued read; data comes off the queue.
  always @(posedge clk) exp_rvld <= rd_issue;

  always @(negedge clk) begin
    if (rvld === 1'b1 || exp_rvld) begin
      check_bit("rvld", rvld, exp_rvld);
      if (exp_rvld && exp_q.size() > 0) begin
        if (rvld === 1'b1) check_output("rdata", rdata, exp_q.pop_front());
        else void'(exp_q.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input logic we, input logic [BW-1:0] ben, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
    @(negedge clk);
    req = 1'b1; we_i = we; ben_i = ben; addr_i = addr; wdata_i = wdata;
    #1;
    check_bit("gnt", gnt, 1'b1);
    if (!we) begin
      check_bit("rd_csel", sram_csel, 1'b1);
      check_bit("rd_wren", sram_we, 1'b0);
      check_output("rd_addr", DW'(sram_addr), DW'(addr));
      exp_q.push_back(exp_rdata);
      rd_issue = 1'b1;
    end else if (ben == '1) begin
      check_bit("wr_csel", sram_csel, 1'b1);
      check_bit("wr_wren", sram_we, 1'b1);
      check_output("wr_data", sram_wdata, wdata);
    end else if (ben == '0) begin
      check_bit("nobe_csel", sram_csel, 1'b0);
    end else begin
      check_bit("rmw_rd_csel", sram_csel, 1'b1);
      check_bit("rmw_rd_wren", sram_we, 1'b0);
    end
    @(posedge clk);
    #1;
    req = 1'b0; we_i = 1'b0; rd_issue = 1'b0;
    if (we && ben != '0 && ben != '1) begin
      @(negedge clk);
      check_bit("rmw_gnt_low", gnt, 1'b0);
      check_bit("rmw_wren", sram_we, 1'b1);
      check_output("rmw_addr", DW'(sram_addr), DW'(addr));
    end
  endtask

  // Expects the next n negedges to be sweep writes at addresses 0..n-1; a full sweep ends in IDLE.
  task automatic check_sweep(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_output("sweep", DW'({gnt, sram_csel, sram_we, init_done, sram_addr}),
                   DW'({1'b0, 1'b1, 1'b1, 1'b0, k[AW-1:0]}));
      check_output("sweep_wdata", sram_wdata, '0);
    end
    if (n == DEPTH) begin
      @(negedge clk);
      check_bit("init_done", init_done, 1'b1);
      check_bit("idle_gnt", gnt, 1'b1);
      check_bit("idle_csel", sram_csel, 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req = 1'b0; we_i = 1'b0;
    ben_i = '0; addr_i = '0; wdata_i = '0;

    vecs[0]  = '{1'b1, 8'hFF, 8'h10, 64'h1122334455667788, 64'h0};
    vecs[1]  = '{1'b0, 8'h00, 8'h10, 64'h0,                64'h1122334455667788};
    vecs[2]  = '{1'b1, 8'h0F, 8'h10, 64'hAAAAAAAABBBBBBBB, 64'h0};
    vecs[3]  = '{1'b0, 8'h00, 8'h10, 64'h0,                64'h11223344BBBBBBBB};
    vecs[4]  = '{1'b1, 8'h00, 8'h10, 64'hFFFFFFFFFFFFFFFF, 64'h0};
    vecs[5]  = '{1'b0, 8'h00, 8'h10, 64'h0,                64'h11223344BBBBBBBB};
    vecs[6]  = '{1'b1, 8'h81, 8'h20, 64'h0123456789ABCDEF, 64'h0};
    vecs[7]  = '{1'b0, 8'h00, 8'h20, 64'h0,                64'h01000000000000EF};
    vecs[8]  = '{1'b0, 8'h00, 8'hFF, 64'h0,                64'h0};
    vecs[9]  = '{1'b1, 8'hF0, 8'hFF, 64'hDEADBEEFCAFEF00D, 64'h0};
    vecs[10] = '{1'b0, 8'h00, 8'hFF, 64'h0,                64'hDEADBEEF00000000};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 64'h0,                64'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("rst_gnt", gnt, 1'b0);
    check_bit("rst_rvld", rvld, 1'b0);
    check_bit("rst_init_done", init_done, 1'b0);
    check_bit("rst_csel", sram_csel, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_sweep(DEPTH);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].ben, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end

    // Flush wins over a simultaneous request, then the whole array reads back as zero.
    @(negedge clk);
    req = 1'b1; we_i = 1'b0; addr_i = 8'h10; flush = 1'b1;
    #1;
    check_bit("flush_gnt", gnt, 1'b0);
    check_bit("flush_csel", sram_csel, 1'b0);
    @(posedge clk);
    #1 req = 1'b0; flush = 1'b0;
    check_sweep(DEPTH);
    apply_stimulus(1'b0, 8'h00, 8'h10, 64'h0, 64'h0);
    apply_stimulus(1'b0, 8'h00, 8'h20, 64'h0, 64'h0);
    apply_stimulus(1'b0, 8'h00, 8'hFF, 64'h0, 64'h0);

    // Reset lands in RMW_WR: the merged write must never reach the macro.
    apply_stimulus(1'b1, 8'hFF, 8'h30, 64'h5555555555555555, 64'h0);
    @(negedge clk);
    req = 1'b1; we_i = 1'b1; ben_i = 8'h01; addr_i = 8'h30; wdata_i = 64'h77;
    #1;
    check_bit("rmw_pre_gnt", gnt, 1'b1);
    @(posedge clk);
    #1 req = 1'b0; we_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_bit("rmw_abort_csel", sram_csel, 1'b0);
    check_bit("rmw_abort_rvld", rvld, 1'b0);
    check_output("rmw_abort_mem", sram_mem[8'h30], 64'h5555555555555555);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset again mid-sweep at address 100: sweep restarts from 0.
    check_sweep(100);
    @(negedge clk);
    check_output("sweep_at_100", DW'(sram_addr), 64'd100);
    rst = 1'b1;
    #1;
    check_bit("sweep_rst_csel", sram_csel, 1'b0);
    check_bit("sweep_rst_rvld", rvld, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_sweep(DEPTH);
    apply_stimulus(1'b0, 8'h00, 8'h30, 64'h0, 64'h0);

    repeat (3) @(negedge clk);
    check_output("scoreboard_empty", DW'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
